leitor_vetor_mem: RTL
=====================

Name: leitor_vetor_mem

Overview:
- Initiator/master for the 8-bit data memory port (memRead/memWrite/endereco/escreveDado/leDado).
- On a start pulse it reads a vector of `tamanho` bytes beginning at `base`, accumulating the sum and the unsigned maximum.
- It then writes the 8-bit sum back to memory at `destino` and pulses `done`.
- It sits beside the datapath as a small memory-scan accelerator sharing the memory port.

Parameters:
DATA_W, 8, data width of memory words, sum and max
ADDR_W, 8, address width; all address arithmetic is modulo 2^ADDR_W

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
base  input  ADDR_W  first read address, latched on accepted start
tamanho  input  ADDR_W  element count (0..255), latched on accepted start
destino  input  ADDR_W  write-back address, latched on accepted start
busy  output  1  high from accepted start until write-back completes
done  output  1  one-cycle pulse when the result has been written
soma  output  DATA_W  running/final sum, modulo 2^DATA_W
maximo  output  DATA_W  running/final unsigned maximum
estouro  output  1  sticky; set if any addition carried out of DATA_W bits
memRead  output  1  memory read enable (memory captures on falling edge)
memWrite  output  1  memory write enable (memory writes on rising edge)
endereco  output  ADDR_W  memory address
escreveDado  output  DATA_W  memory write data
leDado  input  DATA_W  memory read data, valid after the falling edge of a cycle with memRead=1

Behaviour:
- All outputs are registered.
- Reset: state IDLE; busy, done, memRead, memWrite, estouro = 0; soma, maximo, endereco, escreveDado = 0.
- A write whose memWrite=1 was already launched before the reset edge still lands at that edge. Reset cannot suppress it.
- States: IDLE, LER, ESCREVER.
- IDLE, start=1 at edge E0:
  - Latch base, tamanho and destino.
  - Clear soma, maximo and estouro; set busy=1.
  - If tamanho≠0: endereco<=base, memRead<=1, go to LER.
  - If tamanho=0: go directly to ESCREVER setup (endereco<=destino, escreveDado<=0, memWrite<=1).
- LER, pipelined at one element per cycle:
  - The element at base+i is sampled from leDado at edge E(i+1).
  - At the same edge: soma<=soma+leDado (carry sets estouro); maximo<=max(maximo, leDado).
  - At the same edge, if i<tamanho-1: endereco<=base+i+1.
- Leaving LER, at edge E(tamanho), the last sample:
  - memRead<=0; endereco<=destino; memWrite<=1.
  - escreveDado<=final sum, which includes the last element.
  - Go to ESCREVER.
- ESCREVER, one cycle:
  - Memory writes at the next edge, E(tamanho+1).
  - At that edge: memWrite<=0, busy<=0, done<=1, go to IDLE.
- done is high for exactly one cycle.
- A new start is accepted on the edge where done is high; the latency from start to done is then tamanho+1 edges.
- start while busy is ignored. Changes to base/tamanho/destino while busy have no effect.
- Address wrap: base+i computed modulo 2^ADDR_W.
- memRead and memWrite are never simultaneously 1.
- soma and maximo hold their final values until the next accepted start.
- destino may overlap the read range. The write always occurs after all reads.

Test Plan:
- MEM[0..6]={1,2,3,4,5,6,7}; start with base=0, tamanho=7, destino=16:
  - 7 consecutive reads of addresses 0..6 with memRead=1.
  - MEM[16]=28; soma=28, maximo=7, estouro=0.
  - done pulses one cycle exactly 8 edges after the start edge; busy high for those 8 cycles.
- MEM[254]=10, MEM[255]=20, MEM[0]=30, MEM[1]=40; base=254, tamanho=4, destino=100:
  - Addresses issued are 254, 255, 0, 1.
  - MEM[100]=100; maximo=40.
- MEM[8]=200, MEM[9]=100, MEM[10]=3; base=8, tamanho=3, destino=11:
  - soma=47 (303 mod 256), estouro=1, maximo=200, MEM[11]=47.
- tamanho=0, destino=20, MEM[20]=99 beforehand:
  - No memRead cycle.
  - MEM[20]=0; done 1 edge after start.
- Start re-pulsed every cycle while busy during the first scenario:
  - Ignored; results identical.
  - A second start on the done edge is accepted immediately.
- Reset asserted mid-LER (after 3 reads):
  - Next cycle all outputs are 0 and state is IDLE.
  - No write occurs; MEM[16] unchanged; done never pulses.

Source files
------------

// File: rtl/leitor_vetor_mem.sv
// leitor_vetor_mem: memory-scan accelerator that reads a byte vector,
// accumulates sum/max and writes the sum back to memory.
// Ports:
//   clock, reset           : clock, sync active-high reset
//   start                  : one-cycle request, taken only when idle
//   base, tamanho, destino : vector start, length, write-back address
//   busy, done             : job in flight / one-cycle completion pulse
//   soma, maximo, estouro  : running sum, unsigned max, sticky carry
//   memRead, memWrite      : memory port enables (never both high)
//   endereco, escreveDado  : memory address / write data
//   leDado                 : memory read data
module leitor_vetor_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] tamanho,
  input  logic [ADDR_W-1:0] destino,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] soma,
  output logic [DATA_W-1:0] maximo,
  output logic              estouro,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] escreveDado,
  input  logic [DATA_W-1:0] leDado
);

  typedef enum logic [1:0] {
    IDLE,
    LER,
    ESCREVER
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] tam_q, tam_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] soma_q, soma_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              est_q, est_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  // One extra bit catches the carry out of the accumulator.
  logic [DATA_W:0]   add;
  logic [DATA_W-1:0] max_n;
  logic              last;

  assign add   = {1'b0, soma_q} + {1'b0, leDado};
  assign max_n = (leDado > max_q) ? leDado : max_q;
  assign last  = (idx_q == tam_q - ADDR_W'(1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    tam_d   = tam_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    soma_d  = soma_q;
    max_d   = max_q;
    est_d   = est_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base;
          tam_d  = tamanho;
          dest_d = destino;
          idx_d  = '0;
          soma_d = '0;
          max_d  = '0;
          est_d  = 1'b0;
          busy_d = 1'b1;
          if (tamanho != '0) begin
            addr_d  = base;
            rd_d    = 1'b1;
            state_d = LER;
          end else begin
            addr_d  = destino;
            wd_d    = '0;
            wr_d    = 1'b1;
            state_d = ESCREVER;
          end
        end
      end
      LER: begin
        // leDado holds element idx_q, captured on the falling edge.
        soma_d = add[DATA_W-1:0];
        est_d  = est_q | add[DATA_W];
        max_d  = max_n;
        if (last) begin
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          addr_d  = dest_q;
          wd_d    = add[DATA_W-1:0];
          state_d = ESCREVER;
        end else begin
          addr_d = base_q + idx_q + ADDR_W'(1);
          idx_d  = idx_q + ADDR_W'(1);
        end
      end
      ESCREVER: begin
        wr_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      tam_q   <= '0;
      dest_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      soma_q  <= '0;
      max_q   <= '0;
      est_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      tam_q   <= tam_d;
      dest_q  <= dest_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      soma_q  <= soma_d;
      max_q   <= max_d;
      est_q   <= est_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign soma        = soma_q;
  assign maximo      = max_q;
  assign estouro     = est_q;
  assign memRead     = rd_q;
  assign memWrite    = wr_q;
  assign endereco    = addr_q;
  assign escreveDado = wd_q;

endmodule
